// File: rtl/ram_rw.sv
// Writable program RAM that sweeps itself to a known image after reset or on request.
// Define RAM_BOOT_IMAGE_EN to load the boot image instead of zeros during the sweep.
module ram_rw #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              reinit,
    output logic [WIDTH-1:0]  data_out,
    output logic              busy,
    output logic              acc_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0]  data_next;
    logic              err_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  sweep_word;
    logic [WIDTH-1:0]  mem [DEPTH];

`ifdef RAM_BOOT_IMAGE_EN
    // Image entries beyond DEPTH-1 can never be addressed, so they drop out naturally.
    function automatic logic [WIDTH-1:0] init_word(input logic [ADDR_W-1:0] k);
        logic [WIDTH-1:0] w;
        w = '0;
        case (int'(k))
            0:       w[7:0] = 8'h4B;
            1:       w[7:0] = 8'h1F;
            2:       w[7:0] = 8'h2E;
            3:       w[7:0] = 8'hF0;
            14:      w[7:0] = 8'h2A;
            15:      w[7:0] = 8'h2F;
            default: w = '0;
        endcase
        return w;
    endfunction

    assign sweep_word = init_word(cnt);
`else
    assign sweep_word = '0;
`endif

    assign busy = (state == INIT);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= INIT;
            cnt      <= '0;
            data_out <= '0;
            acc_err  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            data_out <= data_next;
            acc_err  <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        data_next  = data_out;
        err_next   = acc_err;
        mem_we     = 1'b0;
        mem_addr   = address;
        mem_wdata  = data_in;
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = sweep_word;
                cnt_next  = cnt + 1'b1;
                if (cnt == '1)
                    state_next = READY;
                if (en)
                    err_next = 1'b1;
            end
            READY: begin
                // A re-init request outranks any access presented in the same cycle.
                if (reinit) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end else if (en) begin
                    if (we) begin
                        mem_we    = 1'b1;
                        data_next = data_in;
                    end else begin
                        data_next = mem[address];
                    end
                end
            end
            default: state_next = INIT;
        endcase
    end

    // Storage has no reset; the sweep overwrites every word before access is allowed.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_ram_rw.sv
// Self-checking bench for ram_rw: default 16x8 instance plus a 64x16 instance.
// Follows whichever image RAM_BOOT_IMAGE_EN selects.
module tb_ram_rw;

`ifdef RAM_BOOT_IMAGE_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_a, en_a, we_a, reinit_a;
    logic [3:0] addr_a;
    logic [7:0] din_a, dout_a;
    logic       busy_a, err_a;

    logic        res_b, en_b, we_b, reinit_b;
    logic [5:0]  addr_b;
    logic [15:0] din_b, dout_b;
    logic        busy_b, err_b;

    ram_rw #(.WIDTH(8), .ADDR_W(4)) dut_a (
        .clk(clk), .res(res_a), .en(en_a), .we(we_a), .address(addr_a),
        .data_in(din_a), .reinit(reinit_a), .data_out(dout_a),
        .busy(busy_a), .acc_err(err_a)
    );

    ram_rw #(.WIDTH(16), .ADDR_W(6)) dut_b (
        .clk(clk), .res(res_b), .en(en_b), .we(we_b), .address(addr_b),
        .data_in(din_b), .reinit(reinit_b), .data_out(dout_b),
        .busy(busy_b), .acc_err(err_b)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] dout;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] rd_q[$];

    logic [7:0]  m_mem [16];
    logic [7:0]  m_dout;
    logic        m_busy, m_err;
    int          m_cnt;
    logic [15:0] mb_mem [64];

    function automatic logic [15:0] boot_val(input int k);
        logic [15:0] v;
        case (k)
            0:       v = 16'h004B;
            1:       v = 16'h001F;
            2:       v = 16'h002E;
            3:       v = 16'h00F0;
            14:      v = 16'h002A;
            15:      v = 16'h002F;
            default: v = 16'h0000;
        endcase
        return BOOT_EN ? v : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_cnt  = 0;
        m_dout = 8'h00;
        m_err  = 1'b0;
    endtask

    // One clock of dut_a: drive, predict into the scoreboard, then compare after the edge.
    task automatic step_a(input logic e, input logic w, input logic r,
                          input logic [3:0] a, input logic [7:0] d, input string tag);
        exp_t ex;
        en_a = e; we_a = w; reinit_a = r; addr_a = a; din_a = d;
        if (m_busy) begin
            if (e) m_err = 1'b1;
            m_mem[m_cnt] = 8'(boot_val(m_cnt));
            if (m_cnt == 15) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end else if (r) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (e && w) begin
            m_mem[a] = d;
            m_dout   = d;
        end else if (e) begin
            m_dout = m_mem[a];
        end
        sb_q.push_back('{dout: m_dout, busy: m_busy, err: m_err});
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        check({tag, " dout"}, 32'(dout_a), 32'(ex.dout));
        check({tag, " busy"}, 32'(busy_a), 32'(ex.busy));
        check({tag, " err"},  32'(err_a),  32'(ex.err));
        en_a = 1'b0; we_a = 1'b0; reinit_a = 1'b0;
    endtask

    task automatic idle_a(input int n, input string tag);
        for (int i = 0; i < n; i++)
            step_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, $sformatf("%s%0d", tag, i));
    endtask

    task automatic access_b(input logic w, input logic [5:0] a, input logic [15:0] d,
                            input string tag);
        en_b = 1'b1; we_b = w; addr_b = a; din_b = d;
        if (w) begin
            mb_mem[a] = d;
            rd_q.push_back(d);
        end else begin
            rd_q.push_back(mb_mem[a]);
        end
        @(posedge clk);
        #1;
        check(tag, 32'(dout_b), 32'(rd_q.pop_front()));
        en_b = 1'b0; we_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fall;
        logic [15:0] pat;
        res_a = 1'b0; en_a = 1'b0; we_a = 1'b0; reinit_a = 1'b0; addr_a = '0; din_a = '0;
        res_b = 1'b0; en_b = 1'b0; we_b = 1'b0; reinit_b = 1'b0; addr_b = '0; din_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst dout", 32'(dout_a), 32'h0);
        check("rst busy", 32'(busy_a), 32'h1);
        check("rst err",  32'(err_a),  32'h0);
        check("rst b busy", 32'(busy_b), 32'h1);
        model_reset();
        res_a = 1'b1;

        // Initial sweep with an illegal access on sweep edge 5.
        for (int i = 1; i <= 16; i++)
            step_a(i == 5, 1'b0, 1'b0, 4'd9, 8'h00, $sformatf("sweep%0d", i));
        check("busy fell after 16", 32'(busy_a), 32'h0);
        check("err sticky", 32'(err_a), 32'h1);

        step_a(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, "rd0");
        check("boot0", 32'(dout_a), BOOT_EN ? 32'h4B : 32'h0);
        step_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00, "rd3");
        check("boot3", 32'(dout_a), BOOT_EN ? 32'hF0 : 32'h0);
        step_a(1'b1, 1'b0, 1'b0, 4'd14, 8'h00, "rd14");
        check("boot14", 32'(dout_a), BOOT_EN ? 32'h2A : 32'h0);

        step_a(1'b1, 1'b1, 1'b0, 4'd7, 8'hA5, "wr7");
        check("wr7 through", 32'(dout_a), 32'hA5);
        step_a(1'b1, 1'b0, 1'b0, 4'd7, 8'h00, "rd7");
        check("rd7 back", 32'(dout_a), 32'hA5);

        // Reinit outranks a same-cycle read; a second reinit mid-sweep is ignored.
        step_a(1'b1, 1'b1, 1'b0, 4'd2, 8'h3C, "wr2");
        step_a(1'b1, 1'b0, 1'b1, 4'd2, 8'h00, "reinit_rd2");
        check("reinit holds dout", 32'(dout_a), 32'h3C);
        idle_a(7, "ri_a");
        step_a(1'b0, 1'b0, 1'b1, 4'd0, 8'h00, "reinit_in_init");
        idle_a(7, "ri_b");
        check("reinit busy still", 32'(busy_a), 32'h1);
        idle_a(1, "ri_c");
        check("reinit busy fell", 32'(busy_a), 32'h0);
        step_a(1'b1, 1'b0, 1'b0, 4'd2, 8'h00, "rd2_init");
        check("rd2 init value", 32'(dout_a), BOOT_EN ? 32'h2E : 32'h0);
        check("err still sticky", 32'(err_a), 32'h1);

        // Async reset at sweep edge 8.
        step_a(1'b0, 1'b0, 1'b1, 4'd0, 8'h00, "reinit2");
        idle_a(8, "mid");
        res_a = 1'b0;
        #1;
        check("async rst dout", 32'(dout_a), 32'h0);
        check("async rst busy", 32'(busy_a), 32'h1);
        check("async rst err",  32'(err_a),  32'h0);
        model_reset();
        #2;
        res_a = 1'b1;
        idle_a(15, "resweep");
        check("resweep busy 15", 32'(busy_a), 32'h1);
        idle_a(1, "resweep_last");
        check("resweep busy 16", 32'(busy_a), 32'h0);

        for (int i = 0; i < 24; i++)
            step_a(1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)),
                   8'($urandom_range(0, 255)), $sformatf("rand%0d", i));

        // Wide instance: 64-word sweep, boot contents, full write/read pass.
        res_b = 1'b1;
        fall = 0;
        for (int i = 1; i <= 80 && fall == 0; i++) begin
            @(posedge clk);
            #1;
            if (!busy_b) fall = i;
        end
        check("B busy edges", 32'(fall), 32'd64);
        for (int k = 0; k < 64; k++)
            mb_mem[k] = boot_val(k);
        access_b(1'b0, 6'd63, 16'h0, "B rd63");
        check("B boot63", 32'(dout_b), 32'h0);
        access_b(1'b0, 6'd1, 16'h0, "B rd1");
        check("B boot1", 32'(dout_b), BOOT_EN ? 32'h001F : 32'h0);
        for (int k = 0; k < 64; k++) begin
            pat = 16'(k * 16'h0103) ^ 16'hA55A;
            access_b(1'b1, 6'(k), pat, $sformatf("B wr%0d", k));
        end
        for (int k = 0; k < 64; k++)
            access_b(1'b0, 6'(k), 16'h0, $sformatf("B rd%0d", k));
        check("B err", 32'(err_b), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
